// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int   c_CLKS_PER_BIT = 434;
    localparam int   c_DATA_BITS    = 8;
    localparam logic c_START_BIT    = 1'b0;
    localparam logic c_STOP_BIT     = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// Module      : uart_rx_if
// Description : Serial line and received-byte signals of the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
    import uart_pkg::*;

    logic                   uart_rx_data;
    logic [c_DATA_BITS-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_frame_err;
    logic                   rx_busy;

    modport master (
        output uart_rx_data,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

    modport slave (
        input  uart_rx_data,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

endinterface

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// Module      : uart_sync
// Description : N-flop synchroniser for an asynchronous input, resets to 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_sync
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, mid-bit sampling, valid / framing strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
    parameter int DATA_BITS    = c_DATA_BITS,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic RST_clk,
    input  wire logic RST_n,
    uart_rx_if.slave  bus
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         c_IDX_LAST = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 r_rx_prev;
    uart_state_t          r_state,   w_state_nxt;
    logic [c_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]           r_bit_idx, w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
    logic                 r_valid,   w_valid_nxt;
    logic                 r_ferr,    w_ferr_nxt;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (RST_clk),
        .rst     (RST_n),
        .i_async (bus.uart_rx_data),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge RST_clk) begin
        if (RST_n) begin
            r_rx_prev <= 1'b1;
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_rx_data_nxt = r_rx_data;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_bit_cnt_nxt = '0;
                if (!w_rx_s && r_rx_prev) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_bit_cnt == c_CNT_HALF) begin
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = (w_rx_s == c_START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (r_bit_cnt == c_CNT_LAST) begin
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == c_IDX_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets an immediately following start edge be caught.
                if (r_bit_cnt == c_CNT_LAST) begin
                    w_bit_cnt_nxt = '0;
                    if (w_rx_s == c_STOP_BIT) begin
                        w_rx_data_nxt = r_shift;
                        w_valid_nxt   = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_ferr_nxt    = 1'b1;
                        w_state_nxt   = BREAK;
                    end
                end
            end
            BREAK: begin
                w_bit_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_bit_cnt_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    assign bus.rx_data      = r_rx_data;
    assign bus.rx_valid     = r_valid;
    assign bus.rx_frame_err = r_ferr;
    assign bus.rx_busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int c_CPB = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   n_valid;
    int   n_ferr;
    int   n_both;
    int   ferr_cyc;
    int   start_cyc;
    int   base;
    logic [7:0] vq[$];
    int         vc[$];

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT (c_CPB),
        .DATA_BITS    (8),
        .SYNC_STAGES  (2)
    ) dut (
        .RST_clk (clk),
        .RST_n   (rst),
        .bus     (u_if.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Outputs are observed on the falling edge; cyc counts falling edges.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (u_if.rx_valid) begin
            n_valid = n_valid + 1;
            vq.push_back(u_if.rx_data);
            vc.push_back(cyc);
        end
        if (u_if.rx_frame_err) begin
            n_ferr   = n_ferr + 1;
            ferr_cyc = cyc;
        end
        if (u_if.rx_valid && u_if.rx_frame_err) begin
            n_both = n_both + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        u_if.uart_rx_data = v;
        idle(c_CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    initial begin
        int v0;
        int f0;
        logic [7:0] byte99;
        n_checks = 0; n_errors = 0; cyc = 0;
        n_valid = 0; n_ferr = 0; n_both = 0; ferr_cyc = 0; start_cyc = 0;
        byte99 = 8'h99;
        rst = 1'b1;
        u_if.uart_rx_data = 1'b1;
        idle(5);
        rst = 1'b0;

        check_val("reset_data",  32'(u_if.rx_data),      32'h00);
        check_val("reset_valid", 32'(u_if.rx_valid),     32'h0);
        check_val("reset_ferr",  32'(u_if.rx_frame_err), 32'h0);
        check_val("reset_busy",  32'(u_if.rx_busy),      32'h0);
        idle(10);

        // Frame 0xAA; valid lands 156 falling edges after the pin drops.
        v0 = n_valid; f0 = n_ferr;
        fork
            send_frame(8'hAA, 1'b1);
            begin
                repeat (3) @(negedge clk);
                #1 check_val("aa_busy_t0", 32'(u_if.rx_busy), 32'h0);
                @(negedge clk);
                #1 check_val("aa_busy_t1", 32'(u_if.rx_busy), 32'h1);
            end
        join
        idle(20);
        check_val("aa_count",   32'(n_valid - v0), 32'd1);
        check_val("aa_latency", 32'(vc[vc.size()-1] - start_cyc), 32'd156);
        check_val("aa_data",    32'(u_if.rx_data), 32'hAA);
        check_val("aa_ferr",    32'(n_ferr - f0),  32'd0);
        check_val("aa_busy_end", 32'(u_if.rx_busy), 32'h0);

        // Back-to-back frames with no idle gap.
        v0 = n_valid;
        send_frame(8'h55, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(20);
        check_val("b2b_count", 32'(n_valid - v0), 32'd2);
        if (vq.size() >= 2) begin
            check_val("b2b_first",  32'(vq[vq.size()-2]), 32'h55);
            check_val("b2b_second", 32'(vq[vq.size()-1]), 32'h0F);
            check_val("b2b_gap",    32'(vc[vc.size()-1] - vc[vc.size()-2]), 32'd160);
        end

        // Four-cycle glitch rejected at the half-bit sample.
        v0 = n_valid; f0 = n_ferr;
        fork
            begin
                start_cyc = cyc;
                u_if.uart_rx_data = 1'b0;
                idle(4);
                u_if.uart_rx_data = 1'b1;
            end
            begin
                repeat (11) @(negedge clk);
                #1 check_val("glitch_busy_t8", 32'(u_if.rx_busy), 32'h1);
                @(negedge clk);
                #1 check_val("glitch_busy_t9", 32'(u_if.rx_busy), 32'h0);
            end
        join
        idle(40);
        check_val("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        check_val("glitch_no_ferr",  32'(n_ferr - f0),  32'd0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check_val("after_glitch_count", 32'(n_valid - v0), 32'd1);
        check_val("after_glitch_data",  32'(u_if.rx_data), 32'h3C);

        // Bad stop bit followed by a held-low line.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hF0, 1'b0);
        idle(40);
        check_val("ferr_count",   32'(n_ferr - f0), 32'd1);
        check_val("ferr_latency", 32'(ferr_cyc - start_cyc), 32'd156);
        check_val("ferr_data_kept", 32'(u_if.rx_data), 32'h3C);
        check_val("ferr_no_valid", 32'(n_valid - v0), 32'd0);
        check_val("break_busy",   32'(u_if.rx_busy), 32'h1);
        u_if.uart_rx_data = 1'b1;
        idle(20);
        check_val("break_exit_busy", 32'(u_if.rx_busy), 32'h0);
        send_frame(8'h81, 1'b1);
        idle(20);
        check_val("after_break_count", 32'(n_valid - v0), 32'd1);
        check_val("after_break_data",  32'(u_if.rx_data), 32'h81);
        check_val("after_break_ferr",  32'(n_ferr - f0),  32'd1);

        // Reset mid-frame at data bit 4 of 0x99; the line is then released high.
        v0 = n_valid; f0 = n_ferr;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(byte99[i]);
        u_if.uart_rx_data = byte99[4];
        idle(8);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_val("midrst_data",  32'(u_if.rx_data),      32'h00);
        check_val("midrst_valid", 32'(u_if.rx_valid),     32'h0);
        check_val("midrst_ferr",  32'(u_if.rx_frame_err), 32'h0);
        check_val("midrst_busy",  32'(u_if.rx_busy),      32'h0);
        u_if.uart_rx_data = 1'b1;
        idle(200);
        check_val("midrst_no_valid", 32'(n_valid - v0), 32'd0);
        send_frame(8'h42, 1'b1);
        idle(20);
        check_val("after_rst_count", 32'(n_valid - v0), 32'd1);
        check_val("after_rst_data",  32'(u_if.rx_data), 32'h42);

        // Loopback-style stream of repeated 0xAA frames.
        v0 = n_valid; f0 = n_ferr;
        base = vq.size();
        for (int i = 0; i < 4; i++) send_frame(8'hAA, 1'b1);
        idle(20);
        check_val("loop_count", 32'(n_valid - v0), 32'd4);
        for (int i = base; i < vq.size(); i++) begin
            check_val("loop_data", 32'(vq[i]), 32'hAA);
        end
        check_val("loop_ferr", 32'(n_ferr - f0), 32'd0);
        check_val("never_both", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial-to-parallel UART receiver: the stage downstream of the board's UART transmitter. Runs in the 50 MHz system clock domain and takes the asynchronous serial line. Frame format is 8N1, LSB first. Each good frame yields one byte plus a one-cycle valid strobe; a bad stop bit yields a framing-error strobe. Used for loopback checking of the ADC serial stream and for host commands.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit period (50 MHz / 115200); legal range >= 4
DATA_BITS, 8, data bits per frame; fixed at 8 in this revision
SYNC_STAGES, 2, synchroniser flops on the serial input; legal range >= 2

Ports:
RST_clk  input  1  system clock, 50 MHz; all logic on rising edge
RST_n  input  1  reset; synchronous, active-high (1 = reset)
uart_rx_data  input  1  asynchronous serial line; idles high
rx_data  output  8  last correctly received byte
rx_valid  output  1  one-cycle strobe: rx_data updated this cycle
rx_frame_err  output  1  one-cycle strobe: stop bit sampled low
rx_busy  output  1  high while a frame is being received (any state other than IDLE)

Behaviour:
- Reset (RST_n = 1 at a clock edge) forces: synchroniser flops = 1; state = IDLE; counters = 0; rx_data = 0x00; rx_valid = 0; rx_frame_err = 0; rx_busy = 0. Reset overrides everything, including mid-frame; no partial byte is ever emitted.
- Synchronisation: uart_rx_data passes through SYNC_STAGES flops giving rx_s. All decisions use rx_s only. Pin-to-rx_s latency is SYNC_STAGES cycles.
- HALF = CLKS_PER_BIT/2, truncated. bit_cnt counts 0..CLKS_PER_BIT-1. bit_idx is 3 bits.
- IDLE: on rx_s = 0 with previous rx_s = 1 (falling edge; call this cycle t0), clear bit_cnt and go to START.
- START: sample at t0+HALF.
  - rx_s = 0 -> go to DATA, clear bit_cnt and bit_idx.
  - rx_s = 1 -> treat as a glitch; return to IDLE with no strobe.
- DATA: data bit k (k = 0..7) is sampled at t0+HALF+(k+1)*CLKS_PER_BIT.
  - Sampled bit is shifted into bit 7 of the shift register, shifting right (LSB first).
  - After bit 7 is sampled, go to STOP.
- STOP: sample at t0+HALF+9*CLKS_PER_BIT.
  - rx_s = 1 -> next cycle: rx_data <= shift register, rx_valid = 1 for exactly one cycle; go to IDLE.
  - rx_s = 0 -> next cycle: rx_frame_err = 1 for one cycle; rx_data holds its old value; go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. A line held low never produces a second frame.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving immediately after the stop bit is caught. No minimum idle gap is required.
- rx_valid and rx_frame_err are never high in the same cycle.
- rx_data is stable between rx_valid strobes.
- Line edges in DATA/STOP are ignored; only sample instants matter.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}
  - START_BIT = 0, STOP_BIT = 1, DATA_BITS = 8, default CLKS_PER_BIT
  - The transmitter uses the same constants.
- One natural sub-module: uart_sync, an N-flop input synchroniser with reset value 1. Reusable for other asynchronous pins such as the ADC busy signal.

Test Plan:
All scenarios use CLKS_PER_BIT = 16 and SYNC_STAGES = 2.
1. Drive frame 0xAA (line sequence 0,0,1,0,1,0,1,0,1,1) -> rx_valid high for 1 cycle at t0+8+9*16+1; rx_data = 0xAA; rx_frame_err stays 0; rx_busy high from t0+1 until the valid cycle.
2. Frames 0x55 then 0x0F back-to-back, zero idle gap -> two rx_valid strobes 160 cycles apart; rx_data = 0x55 then 0x0F.
3. Line pulled low for 4 cycles, then high -> no strobe; rx_busy drops by t0+9; a following 0x3C frame is received correctly.
4. Frame 0xF0 with stop bit driven 0, line held low 40 cycles -> rx_frame_err strobes once; rx_data keeps its prior value (0x3C); no further strobe until the line returns high and a new frame 0x81 is received correctly.
5. Assert RST_n = 1 for one cycle at data bit 4 of frame 0x99 -> all outputs return to reset values; no rx_valid; the next frame 0x42 is received correctly.
6. Loopback from the UART transmitter sending 8'b10101010 repeatedly -> every frame gives rx_valid with rx_data = 0xAA, and rx_frame_err never asserts.
